// File: rtl/output_membrane_accumulator_pkg.sv
// Shared types and constants for the output-layer membrane accumulator.
// Clamp limits below are for the default membrane width.
package output_membrane_accumulator_pkg;

    localparam int NUM_OUT_NEURONS = 5;
    localparam int MEM_W           = 16;

    localparam logic signed [MEM_W-1:0] MEM_MAX = {1'b0, {(MEM_W-1){1'b1}}};
    localparam logic signed [MEM_W-1:0] MEM_MIN = {1'b1, {(MEM_W-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/output_membrane_accumulator_sat_add_signed.sv
// Combinational signed saturating adder: acc + sext(addend), clamped to the
// acc range. ADD_W must not exceed ACC_W.
module sat_add_signed #(
    parameter int ACC_W = 16,
    parameter int ADD_W = 8
) (
    input  logic [ACC_W-1:0] acc,
    input  logic [ADD_W-1:0] addend,
    output logic [ACC_W-1:0] sum
);

    localparam logic [ACC_W-1:0] SAT_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] SAT_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    logic [ACC_W:0] wide;

    // One guard bit: the top two bits differ only when both operands shared
    // a sign and the W-bit result flipped it; the guard bit holds the true sign.
    always_comb begin
        wide = {acc[ACC_W-1], acc}
             + {{(ACC_W+1-ADD_W){addend[ADD_W-1]}}, addend};
        if (wide[ACC_W] != wide[ACC_W-1]) begin
            sum = wide[ACC_W] ? SAT_MIN : SAT_MAX;
        end else begin
            sum = wide[ACC_W-1:0];
        end
    end

endmodule

// File: rtl/output_membrane_accumulator.sv
// Accumulates signed contributions into five output membranes over an inference,
// then holds them frozen behind a valid/ready handshake for the loser comparator.
module output_membrane_accumulator
    import output_membrane_accumulator_pkg::*;
#(
    parameter int BIT_WIDTH_BIG_MEMBRANE = 16,
    parameter int BIT_WIDTH_CONTRIB      = 8,
    parameter int BIT_WIDTH_BEAT_CNT     = 12
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic                              start_i,
    input  logic                              in_valid_i,
    output logic                              in_ready_o,
    input  logic [2:0]                        in_idx_i,
    input  logic [BIT_WIDTH_CONTRIB-1:0]      in_value_i,
    input  logic                              in_last_i,
    output logic [BIT_WIDTH_BIG_MEMBRANE-1:0] variable0_o,
    output logic [BIT_WIDTH_BIG_MEMBRANE-1:0] variable1_o,
    output logic [BIT_WIDTH_BIG_MEMBRANE-1:0] variable2_o,
    output logic [BIT_WIDTH_BIG_MEMBRANE-1:0] variable3_o,
    output logic [BIT_WIDTH_BIG_MEMBRANE-1:0] variable4_o,
    output logic                              out_valid_o,
    input  logic                              out_ready_i,
    output logic [BIT_WIDTH_BEAT_CNT-1:0]     beat_count_o,
    output logic                              idx_err_o
);

    state_t state, state_next;

    logic [BIT_WIDTH_BIG_MEMBRANE-1:0] acc [NUM_OUT_NEURONS];
    logic [BIT_WIDTH_BIG_MEMBRANE-1:0] sel_acc;
    logic [BIT_WIDTH_BIG_MEMBRANE-1:0] sum_acc;
    logic [BIT_WIDTH_BEAT_CNT-1:0]     beat_cnt;
    logic                              idx_err;
    logic                              idx_ok;
    logic                              accept;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start_i)                state_next = ACCUM;
            ACCUM:   if (accept && in_last_i)    state_next = DONE;
            DONE:    if (out_ready_i)            state_next = IDLE;
            default:                             state_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready_o  = 1'b0;
        out_valid_o = 1'b0;
        case (state)
            ACCUM:   in_ready_o  = 1'b1;
            DONE:    out_valid_o = 1'b1;
            default: ;
        endcase
    end

    assign accept = in_valid_i && in_ready_o;
    assign idx_ok = (in_idx_i < 3'(NUM_OUT_NEURONS));

    always_comb begin
        sel_acc = '0;
        for (int unsigned i = 0; i < NUM_OUT_NEURONS; i++) begin
            if (in_idx_i == 3'(i)) sel_acc = acc[i];
        end
    end

    sat_add_signed #(
        .ACC_W (BIT_WIDTH_BIG_MEMBRANE),
        .ADD_W (BIT_WIDTH_CONTRIB)
    ) u_sat_add (
        .acc    (sel_acc),
        .addend (in_value_i),
        .sum    (sum_acc)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < NUM_OUT_NEURONS; i++) acc[i] <= '0;
            beat_cnt <= '0;
            idx_err  <= 1'b0;
        end else if (state == IDLE && start_i) begin
            for (int unsigned i = 0; i < NUM_OUT_NEURONS; i++) acc[i] <= '0;
            beat_cnt <= '0;
            idx_err  <= 1'b0;
        end else if (accept) begin
            if (idx_ok) begin
                for (int unsigned i = 0; i < NUM_OUT_NEURONS; i++) begin
                    if (in_idx_i == 3'(i)) acc[i] <= sum_acc;
                end
            end else begin
                idx_err <= 1'b1;
            end
            if (beat_cnt != '1) beat_cnt <= beat_cnt + 1'b1;
        end
    end

    assign variable0_o  = acc[0];
    assign variable1_o  = acc[1];
    assign variable2_o  = acc[2];
    assign variable3_o  = acc[3];
    assign variable4_o  = acc[4];
    assign beat_count_o = beat_cnt;
    assign idx_err_o    = idx_err;

endmodule

// File: tb/tb_output_membrane_accumulator.sv
// Directed bench for output_membrane_accumulator with hand-computed expectations.
module tb_output_membrane_accumulator;
    import output_membrane_accumulator_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start_i;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [2:0]  in_idx_i;
    logic [7:0]  in_value_i;
    logic        in_last_i;
    logic [15:0] variable0_o, variable1_o, variable2_o, variable3_o, variable4_o;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [11:0] beat_count_o;
    logic        idx_err_o;

    int errors = 0;
    int checks = 0;

    output_membrane_accumulator #(
        .BIT_WIDTH_BIG_MEMBRANE (16),
        .BIT_WIDTH_CONTRIB      (8),
        .BIT_WIDTH_BEAT_CNT     (12)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start_i      (start_i),
        .in_valid_i   (in_valid_i),
        .in_ready_o   (in_ready_o),
        .in_idx_i     (in_idx_i),
        .in_value_i   (in_value_i),
        .in_last_i    (in_last_i),
        .variable0_o  (variable0_o),
        .variable1_o  (variable1_o),
        .variable2_o  (variable2_o),
        .variable3_o  (variable3_o),
        .variable4_o  (variable4_o),
        .out_valid_o  (out_valid_o),
        .out_ready_i  (out_ready_i),
        .beat_count_o (beat_count_o),
        .idx_err_o    (idx_err_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic beat(input logic [2:0] idx, input int val, input logic last);
        in_valid_i = 1'b1;
        in_idx_i   = idx;
        in_value_i = 8'(val);
        in_last_i  = last;
        tick();
        in_valid_i = 1'b0;
        in_last_i  = 1'b0;
    endtask

    task automatic start_inf();
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
    endtask

    task automatic handshake();
        out_ready_i = 1'b1;
        tick();
        out_ready_i = 1'b0;
    endtask

    task automatic chk_vars(input string tag, input int e0, input int e1, input int e2,
                            input int e3, input int e4);
        chk({tag, "_v0"}, int'($signed(variable0_o)), e0);
        chk({tag, "_v1"}, int'($signed(variable1_o)), e1);
        chk({tag, "_v2"}, int'($signed(variable2_o)), e2);
        chk({tag, "_v3"}, int'($signed(variable3_o)), e3);
        chk({tag, "_v4"}, int'($signed(variable4_o)), e4);
    endtask

    initial begin
        logic [9:0] pat;
        logic       seen_valid;

        reset_n     = 1'b0;
        start_i     = 1'b0;
        in_valid_i  = 1'b0;
        in_idx_i    = '0;
        in_value_i  = '0;
        in_last_i   = 1'b0;
        out_ready_i = 1'b0;
        #2;
        chk_vars("rst", 0, 0, 0, 0, 0);
        chk("rst_valid", int'(out_valid_o), 0);
        chk("rst_ready", int'(in_ready_o), 0);
        chk("rst_cnt", int'(beat_count_o), 0);
        chk("rst_err", int'(idx_err_o), 0);
        tick();
        reset_n = 1'b1;
        tick();

        // Basic inference
        start_inf();
        chk("basic_ready", int'(in_ready_o), 1);
        beat(3'd0, 5, 1'b0);
        chk("basic_lat_v0", int'($signed(variable0_o)), 5);
        beat(3'd1, -3, 1'b0);
        beat(3'd4, 100, 1'b0);
        beat(3'd0, 7, 1'b1);
        chk_vars("basic", 12, -3, 0, 0, 100);
        chk("basic_valid", int'(out_valid_o), 1);
        chk("basic_cnt", int'(beat_count_o), 4);
        chk("basic_err", int'(idx_err_o), 0);

        // DONE: held for 10 cycles with a beat offered
        in_valid_i = 1'b1; in_idx_i = 3'd0; in_value_i = 8'd9;
        repeat (10) tick();
        chk("done_ready", int'(in_ready_o), 0);
        chk("done_valid", int'(out_valid_o), 1);
        chk_vars("done_hold", 12, -3, 0, 0, 100);
        chk("done_cnt", int'(beat_count_o), 4);

        // Handshake with concurrent start: start ignored
        out_ready_i = 1'b1; start_i = 1'b1;
        tick();
        out_ready_i = 1'b0; start_i = 1'b0;
        chk("hs_valid", int'(out_valid_o), 0);
        chk("idle_ready", int'(in_ready_o), 0);
        tick();
        chk("idle_nostart", int'(in_ready_o), 0);
        chk("idle_v0", int'($signed(variable0_o)), 12);
        in_valid_i = 1'b0;

        // Positive saturation then a negative last beat
        start_inf();
        chk_vars("clr", 0, 0, 0, 0, 0);
        for (int i = 0; i < 300; i++) beat(3'd2, 127, 1'b0);
        chk("psat_v2", int'($signed(variable2_o)), int'(MEM_MAX));
        chk("psat_cnt", int'(beat_count_o), 300);
        beat(3'd2, -128, 1'b1);
        chk("psat_last_v2", int'($signed(variable2_o)), 32639);
        chk("psat_cnt_last", int'(beat_count_o), 301);
        chk("psat_valid", int'(out_valid_o), 1);
        handshake();

        // Negative saturation
        start_inf();
        for (int i = 0; i < 260; i++) beat(3'd3, -128, 1'b0);
        chk("nsat_v3", int'($signed(variable3_o)), int'($signed(MEM_MIN)));
        beat(3'd3, -1, 1'b1);
        chk("nsat_last_v3", int'($signed(variable3_o)), -32768);
        chk("nsat_cnt", int'(beat_count_o), 261);
        handshake();

        // Bad index
        start_inf();
        beat(3'd0, 10, 1'b0);
        beat(3'd6, 50, 1'b0);
        chk("bad_err", int'(idx_err_o), 1);
        chk_vars("bad_mid", 10, 0, 0, 0, 0);
        beat(3'd1, 20, 1'b1);
        chk_vars("bad_end", 10, 20, 0, 0, 0);
        chk("bad_cnt", int'(beat_count_o), 3);
        chk("bad_err_held", int'(idx_err_o), 1);
        handshake();
        start_inf();
        chk("bad_err_clr", int'(idx_err_o), 0);
        chk("bad_cnt_clr", int'(beat_count_o), 0);

        // Backpressure: only valid cycles accepted
        pat = 10'b1011001101;
        in_idx_i = 3'd4; in_value_i = 8'd1; in_last_i = 1'b0;
        for (int i = 0; i < 10; i++) begin
            in_valid_i = pat[i];
            tick();
        end
        in_valid_i = 1'b0;
        chk("bp_v4", int'($signed(variable4_o)), 6);
        chk("bp_cnt", int'(beat_count_o), 6);
        beat(3'd4, 1, 1'b1);
        chk("bp_v4_last", int'($signed(variable4_o)), 7);
        chk("bp_cnt_last", int'(beat_count_o), 7);
        handshake();

        // Reset mid-inference
        start_inf();
        beat(3'd0, 1, 1'b0);
        beat(3'd0, 1, 1'b0);
        beat(3'd0, 1, 1'b0);
        chk("mid_v0_pre", int'($signed(variable0_o)), 3);
        #2 reset_n = 1'b0;
        #1;
        chk_vars("mid_rst", 0, 0, 0, 0, 0);
        chk("mid_cnt", int'(beat_count_o), 0);
        chk("mid_ready", int'(in_ready_o), 0);
        chk("mid_valid", int'(out_valid_o), 0);
        in_valid_i = 1'b1; in_idx_i = 3'd0; in_value_i = 8'd9; in_last_i = 1'b1;
        tick();
        reset_n = 1'b1;
        seen_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            seen_valid = seen_valid | out_valid_o | in_ready_o;
        end
        in_valid_i = 1'b0; in_last_i = 1'b0;
        chk("mid_no_valid", int'(seen_valid), 0);
        chk("mid_v0_post", int'($signed(variable0_o)), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/output_membrane_accumulator.md
Name: output_membrane_accumulator

Overview:
Upstream stage of the final loser comparator in the SNN output layer. It accumulates signed spike-weighted contributions into five big-membrane registers, one per output neuron, over a whole inference. It then presents the five values, frozen, with a valid/ready handshake, so the combinational loser comparator downstream sees stable inputs. Saturating arithmetic keeps a long inference from wrapping the membrane sign.

Parameters:
BIT_WIDTH_BIG_MEMBRANE, 16, width of each accumulated output membrane (signed).
BIT_WIDTH_CONTRIB, 8, width of each incoming signed contribution.
BIT_WIDTH_BEAT_CNT, 12, width of the accepted-beat counter.

Ports:
clk  input  1  system clock, rising edge.
reset_n  input  1  asynchronous active-low reset.
start_i  input  1  pulse; begins a new inference (honoured in IDLE only).
in_valid_i  input  1  contribution beat valid.
in_ready_o  output  1  block can accept a beat.
in_idx_i  input  3  target neuron index, 0..4.
in_value_i  input  BIT_WIDTH_CONTRIB  signed contribution.
in_last_i  input  1  marks the final beat of the inference.
variable0_o..variable4_o  output  BIT_WIDTH_BIG_MEMBRANE each  accumulated membranes, to the comparator.
out_valid_o  output  1  variableN_o are final and stable.
out_ready_i  input  1  downstream has consumed the result.
beat_count_o  output  BIT_WIDTH_BEAT_CNT  accepted beats this inference, saturating.
idx_err_o  output  1  sticky; a beat with in_idx_i > 4 was accepted this inference.

Behaviour:
- Reset (asynchronous, active-low): state IDLE; all variableN_o = 0; out_valid_o = 0; in_ready_o = 0; beat_count_o = 0; idx_err_o = 0. Reset asserted mid-inference aborts the inference; no partial result is flagged valid.
- States: IDLE, ACCUM, DONE.
- IDLE:
  - in_ready_o = 0. Accumulators hold their last values.
  - start_i = 1 → next cycle: all accumulators 0, beat_count_o 0, idx_err_o 0, state ACCUM.
- ACCUM:
  - in_ready_o = 1. A beat is accepted when in_valid_i && in_ready_o.
  - Accepted beat with idx 0..4: acc[idx] <= sat(acc[idx] + sext(in_value_i)).
  - sat clamps to [-2^(W-1), 2^(W-1)-1]. Overflow is detected from the operand signs and the result sign, at W+1 bits.
  - Accepted beat with idx 5..7: no accumulator changes; idx_err_o <= 1.
  - Every accepted beat increments beat_count_o. The counter saturates at all-ones.
  - Accepted beat with in_last_i = 1: update as above, then state DONE next cycle. The last beat's contribution is included.
  - start_i is ignored in ACCUM.
- DONE:
  - in_ready_o = 0; out_valid_o = 1. variableN_o, beat_count_o and idx_err_o are frozen.
  - out_ready_i = 1 → next cycle out_valid_o = 0, state IDLE.
  - start_i in the same cycle as that handshake is ignored; it must be reasserted in IDLE.
- Latency:
  - An accepted beat is visible on variableN_o one cycle after acceptance.
  - out_valid_o rises one cycle after the last beat is accepted.
  - Minimum inference is start, 1 beat with last, then DONE: 3 cycles.
- variableN_o are registered outputs, driven directly from the accumulators at all times.

Decomposition:
- Shared package: NUM_OUT_NEURONS = 5; the state enum (IDLE, ACCUM, DONE); the clamp constants MEM_MAX and MEM_MIN, derived from BIT_WIDTH_BIG_MEMBRANE.
- One sub-module: sat_add_signed. It is purely combinational, parameterised on accumulator and addend width, and is instantiated once. The selected accumulator is muxed in by idx, and the result is written back only to that index.

Test Plan:
- Basic: start; beats (idx,val) = (0,+5),(1,-3),(4,+100),(0,+7, last). Require variable0..4 = 12,-3,0,0,100; out_valid_o = 1; beat_count_o = 4. Hold out_ready_i = 0 for 10 cycles: outputs stable. Then out_ready_i = 1: IDLE the next cycle.
- Positive saturation: drive idx 2 with +127 for 300 beats, then last. Require variable2_o = 32767, not wrapped. Follow with one -128 beat: result 32639.
- Negative saturation: drive idx 3 with -128 for 260 beats. Require variable3_o = -32768.
- Bad index: beat (6,+50) among valid beats. Require idx_err_o = 1 and no accumulator changed. The next start clears idx_err_o to 0.
- Backpressure/handshake: toggle in_valid_i randomly in ACCUM and check only valid&&ready beats count. In IDLE and DONE, assert in_valid_i with (0,+9): require in_ready_o = 0 and variable0_o unchanged.
- Reset mid-op: deassert reset_n after 3 beats of ACCUM. Require all outputs 0 immediately (asynchronous), state IDLE, and out_valid_o never asserted for the aborted inference.
